// File: rtl/nn_pkg.sv
// Shared definitions for the image neuron MAC.
//   - state_t        : controller states (IDLE, FETCH, DRAIN, DONE)
//   - DEF_*          : default widths for a 4x4 image of 8-bit pixels
//   - acc_width_ok() : true when the accumulator cannot overflow for the
//                      worst-case sum of NUM_PIXELS products plus a bias
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_ACC_WIDTH    = 24;

    // Each product needs DATA+WEIGHT+1 bits; summing 2**ADDR of them grows
    // the magnitude by ADDR bits.
    function automatic bit acc_width_ok(input int data_w, input int weight_w,
                                        input int addr_w, input int acc_w);
        return acc_w >= data_w + weight_w + addr_w + 1;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate slice.
//   clk, rst    : clock, synchronous active-high reset (clears accumulator)
//   load_i      : replace the accumulator with load_val_i (bias)
//   load_val_i  : signed value loaded on load_i
//   acc_en_i    : add pixel_i * weight_i into the accumulator
//   pixel_i     : unsigned pixel
//   weight_i    : signed weight
//   sum_o       : accumulator plus the current product (combinational), so
//                 the caller can capture the final sum in the same cycle
module mac_unit
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [ACC_WIDTH-1:0]    load_val_i,
    input  logic                    acc_en_i,
    input  logic [DATA_WIDTH-1:0]   pixel_i,
    input  logic [WEIGHT_WIDTH-1:0] weight_i,
    output logic [ACC_WIDTH-1:0]    sum_o
);

    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + 1;

    logic signed [PROD_WIDTH-1:0] pixel_ext;
    logic signed [PROD_WIDTH-1:0] weight_ext;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic signed [ACC_WIDTH-1:0]  sum;

    // Pixel is zero-extended (it is unsigned), weight sign-extended; the true
    // product always fits in PROD_WIDTH signed bits, so truncation is exact.
    assign pixel_ext  = {{(WEIGHT_WIDTH + 1){1'b0}}, pixel_i};
    assign weight_ext = {{(DATA_WIDTH + 1){weight_i[WEIGHT_WIDTH-1]}}, weight_i};
    assign prod       = pixel_ext * weight_ext;
    assign prod_ext   = {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign sum        = acc_q + prod_ext;
    assign sum_o      = sum;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (acc_en_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/image_neuron_mac.sv
// Single neuron over a stored image: sweeps every pixel address of a BRAM
// with a 1-cycle registered read port, multiplies each pixel by its weight,
// accumulates onto a bias and optionally applies ReLU.
//   clk, rst          : clock, synchronous active-high reset (aborts any run)
//   start             : request a computation (honoured in IDLE only)
//   busy              : high whenever not IDLE
//   bias              : signed bias, sampled when start is accepted
//   w_we/w_addr/w_data: weight register file write port (IDLE only)
//   mem_read_addr     : registered BRAM read address
//   mem_read_data     : BRAM data, valid one cycle after the address
//   result_valid/ready/data : output handshake. result_valid rises with
//                       result_data stable and both hold until a cycle where
//                       result_ready is high; that edge is the transfer.
module image_neuron_mac
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter bit RELU_EN      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    input  logic [ACC_WIDTH-1:0]    bias,
    input  logic                    w_we,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [WEIGHT_WIDTH-1:0] w_data,
    output logic [ADDR_WIDTH-1:0]   mem_read_addr,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [ACC_WIDTH-1:0]    result_data
);

    localparam int NUM_PIXELS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

    if (!acc_width_ok(DATA_WIDTH, WEIGHT_WIDTH, ADDR_WIDTH, ACC_WIDTH)) begin : g_acc_width_check
        $error("image_neuron_mac: ACC_WIDTH too small for the worst-case sum");
    end

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   addr_d1_q, addr_d1_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    valid_q, valid_d;
    logic [ACC_WIDTH-1:0]    result_q, result_d;
    logic                    acc_load;
    logic [ACC_WIDTH-1:0]    acc_sum;
    logic [WEIGHT_WIDTH-1:0] weight_q [NUM_PIXELS];

    // Weight register file: writable only while idle so a run always sees a
    // frozen set of weights.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                weight_q[i] <= '0;
            end
        end else if (w_we && (state_q == IDLE)) begin
            weight_q[w_addr] <= w_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        addr_d1_d  = addr_d1_q;
        rd_valid_d = 1'b0;
        valid_d    = valid_q;
        result_d   = result_q;
        acc_load   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FETCH;
                    addr_d   = '0;
                    acc_load = 1'b1;
                end
            end
            FETCH: begin
                // The address issued this cycle returns data next cycle;
                // remember which weight belongs to it.
                rd_valid_d = 1'b1;
                addr_d1_d  = addr_q;
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // acc_sum already includes the final pixel's product.
                result_d = (RELU_EN && acc_sum[ACC_WIDTH-1]) ? '0 : acc_sum;
                valid_d  = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            addr_d1_q  <= '0;
            rd_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            addr_d1_q  <= addr_d1_d;
            rd_valid_q <= rd_valid_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
        end
    end

    mac_unit #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .load_i    (acc_load),
        .load_val_i(bias),
        .acc_en_i  (rd_valid_q),
        .pixel_i   (mem_read_data),
        .weight_i  (weight_q[addr_d1_q]),
        .sum_o     (acc_sum)
    );

    assign busy          = (state_q != IDLE);
    assign mem_read_addr = addr_q;
    assign result_valid  = valid_q;
    assign result_data   = result_q;

endmodule

// File: tb/tb_image_neuron_mac.sv
module tb_image_neuron_mac;

    localparam int NP = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        start = 1'b0;
    logic [23:0] bias = '0;
    logic        w_we = 1'b0;
    logic [3:0]  w_addr = '0;
    logic [7:0]  w_data = '0;
    logic        result_ready = 1'b0;

    // Two instances: one with ReLU, one passing the raw sum.
    logic        busy_relu, busy_raw;
    logic [3:0]  addr_relu, addr_raw;
    logic [7:0]  rd_relu, rd_raw;
    logic        valid_relu, valid_raw;
    logic [23:0] res_relu, res_raw;

    image_neuron_mac #(.RELU_EN(1'b1)) u_dut_relu (
        .clk(clk), .rst(rst), .start(start), .busy(busy_relu), .bias(bias),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .mem_read_addr(addr_relu), .mem_read_data(rd_relu),
        .result_valid(valid_relu), .result_ready(result_ready), .result_data(res_relu)
    );

    image_neuron_mac #(.RELU_EN(1'b0)) u_dut_raw (
        .clk(clk), .rst(rst), .start(start), .busy(busy_raw), .bias(bias),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .mem_read_addr(addr_raw), .mem_read_data(rd_raw),
        .result_valid(valid_raw), .result_ready(result_ready), .result_data(res_raw)
    );

    // ---------------- reference image + BRAM models ----------------
    logic [7:0]        pix_m [NP];
    logic signed [7:0] w_m   [NP];

    always @(posedge clk) begin
        rd_relu <= pix_m[addr_relu];
        rd_raw  <= pix_m[addr_raw];
    end

    // Reference: plain dot product plus bias.
    function automatic longint model_raw(input longint b);
        longint s;
        s = b;
        for (int i = 0; i < NP; i++) begin
            s += longint'(pix_m[i]) * longint'(w_m[i]);
        end
        return s;
    endfunction

    function automatic longint relu(input longint v);
        return (v < 0) ? 0 : v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic write_all_weights();
        for (int i = 0; i < NP; i++) begin
            @(negedge clk);
            w_we   = 1'b1;
            w_addr = 4'(i);
            w_data = w_m[i];
        end
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic set_uniform(input int w_val, input int p_val);
        for (int i = 0; i < NP; i++) begin
            w_m[i]   = 8'(w_val);
            pix_m[i] = (p_val < 0) ? 8'(i) : 8'(p_val);
        end
    endtask

    // mode 0: plain run; 1: stall result_ready and poke start in DONE;
    // 2: poke start/w_we during FETCH; 3: write weight[0] in the start cycle.
    task automatic run(input string name, input longint b, input longint exp_raw,
                       input longint exp_relu, input int mode);
        int lat;
        bit addr_ok;
        bit hold_ok;
        @(negedge clk);
        bias  = 24'(b);
        start = 1'b1;
        if (mode == 3) begin
            w_we = 1'b1; w_addr = 4'd0; w_data = 8'd5;
        end
        @(posedge clk); #1;
        start = 1'b0;
        w_we  = 1'b0;
        lat = 1;
        addr_ok = 1'b1;
        check({name, ":busy_after_start"}, longint'(busy_relu & busy_raw), 1);
        while (!(valid_relu && valid_raw) && lat < 40) begin
            if (lat <= NP && (addr_raw != 4'(lat - 1) || addr_relu != 4'(lat - 1))) addr_ok = 1'b0;
            if (mode == 2 && lat == 5) begin
                start = 1'b1; w_we = 1'b1; w_addr = 4'd3; w_data = 8'h80;
            end else begin
                start = 1'b0; w_we = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0; w_we = 1'b0;
        check({name, ":latency"}, lat, NP + 2);
        check({name, ":addr_seq"}, longint'(addr_ok), 1);
        check({name, ":raw"}, longint'($signed(res_raw)), exp_raw);
        check({name, ":relu"}, longint'($signed(res_relu)), exp_relu);
        if (mode == 1) begin
            hold_ok = 1'b1;
            for (int k = 0; k < 5; k++) begin
                start = (k == 2);
                @(posedge clk); #1;
                if (!valid_raw || !valid_relu || !busy_raw) hold_ok = 1'b0;
                if (longint'($signed(res_raw)) != exp_raw) hold_ok = 1'b0;
                if (longint'($signed(res_relu)) != exp_relu) hold_ok = 1'b0;
            end
            check({name, ":stall_hold"}, longint'(hold_ok), 1);
            start = 1'b1;  // also present on the handshake cycle; must be ignored
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start = 1'b0;
        check({name, ":idle_after_hs"}, longint'({busy_raw, busy_relu, valid_raw, valid_relu}), 0);
        check({name, ":addr_hold"}, longint'(addr_raw), NP - 1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string  name;
        int     w_val;
        int     p_val;      // -1: ramp 0..15
        longint b;
        longint exp_raw;
        longint exp_relu;
    } vec_t;

    vec_t vecs [3];

    initial begin
        longint e;
        int lat;
        bit quiet;

        vecs[0] = '{"ramp_w1",    1,   -1,   0,     120,  120};
        vecs[1] = '{"neg_w",     -1,  255,   0,   -4080,    0};
        vecs[2] = '{"min_w",   -128,  255, 100, -522140,    0};

        set_uniform(0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst:busy",  longint'({busy_raw, busy_relu}), 0);
        check("rst:valid", longint'({valid_raw, valid_relu}), 0);
        check("rst:data",  longint'(res_raw | res_relu), 0);
        check("rst:addr",  longint'(addr_raw | addr_relu), 0);

        for (int i = 0; i < 3; i++) begin
            set_uniform(vecs[i].w_val, vecs[i].p_val);
            write_all_weights();
            run(vecs[i].name, vecs[i].b, vecs[i].exp_raw, vecs[i].exp_relu, 0);
        end

        // randomized runs against the reference dot product
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NP; i++) begin
                w_m[i]   = 8'($urandom_range(0, 255));
                pix_m[i] = 8'($urandom_range(0, 255));
            end
            write_all_weights();
            bias = '0;
            e = model_raw(longint'($urandom_range(0, 2000000)) - 1000000);
            run($sformatf("rand%0d", r), e - model_raw(0), e, relu(e), 0);
        end

        // stalled handshake with start poked in DONE
        set_uniform(1, -1);
        write_all_weights();
        run("stall", 0, 120, 120, 1);

        // start/w_we during FETCH must not disturb the run or the weights
        run("fetch_poke", 0, 120, 120, 2);
        run("fetch_poke_after", 0, 120, 120, 0);

        // reset in FETCH cycle 7 aborts and clears weights
        @(negedge clk);
        bias = 24'd999; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (lat < 7) begin
            @(posedge clk); #1;
            lat++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort:busy",  longint'({busy_raw, busy_relu}), 0);
        check("abort:valid", longint'({valid_raw, valid_relu}), 0);
        check("abort:data",  longint'(res_raw | res_relu), 0);
        quiet = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (valid_raw || valid_relu) quiet = 1'b0;
        end
        check("abort:no_result", longint'(quiet), 1);
        set_uniform(0, 200);
        run("bias_only", 42, 42, 42, 0);

        // same-cycle start and weight write: weight[0]=5 is used
        for (int i = 0; i < NP; i++) pix_m[i] = 8'($urandom_range(0, 255));
        w_m[0] = 8'sd5;
        e = model_raw(-3);
        run("start_with_write", -3, e, relu(e), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/image_neuron_mac.md
Name: image_neuron_mac

Overview:
- Downstream consumer of the image BRAM.
- On start, sweeps every pixel address of the stored image and issues reads against the BRAM's 1-cycle registered read port.
- Multiplies each returned unsigned pixel by a signed weight held in an internal weight register file, accumulates onto a bias, and applies optional ReLU.
- Presents one neuron output via a valid/ready handshake to the next layer.

Parameters:
- DATA_WIDTH, 8: pixel width (unsigned); matches the image BRAM data width.
- ADDR_WIDTH, 4: pixel address width; NUM_PIXELS = 2**ADDR_WIDTH (16 for a 4x4 image).
- WEIGHT_WIDTH, 8: signed weight width.
- ACC_WIDTH, 24: signed accumulator/result width. Must be >= DATA_WIDTH+WEIGHT_WIDTH+ADDR_WIDTH+1; elaboration error otherwise.
- RELU_EN, 1: 1 = clamp negative results to 0; 0 = pass the raw sum.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to compute; honoured only in IDLE.
- busy  out  1  high in any state other than IDLE.
- bias  in  ACC_WIDTH  signed bias; sampled on the accepted start edge.
- w_we  in  1  weight write enable; ignored while busy.
- w_addr  in  ADDR_WIDTH  weight index (equals pixel address).
- w_data  in  WEIGHT_WIDTH  signed weight.
- mem_read_addr  out  ADDR_WIDTH  registered address to the BRAM read port.
- mem_read_data  in  DATA_WIDTH  BRAM read data, valid 1 cycle after the address.
- result_valid  out  1  result available.
- result_ready  in  1  downstream accepts the result.
- result_data  out  ACC_WIDTH  signed neuron output.

Behaviour:
- Reset (synchronous), values seen the cycle after the rst edge:
  - state=IDLE, busy=0, result_valid=0, result_data=0, mem_read_addr=0, accumulator=0.
  - All weight registers=0.
  - Reset during any state aborts the operation; no partial result is emitted.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - w_we=1 writes w_data into weight[w_addr].
  - start=1 loads acc<=bias, addr counter<=0, next state FETCH.
- FETCH:
  - Lasts exactly NUM_PIXELS cycles; mem_read_addr = 0,1,...,NUM_PIXELS-1, one per cycle.
  - A one-bit read-valid pipeline flag and a weight index delayed by one cycle track the BRAM latency.
  - From the second FETCH cycle on, acc <= acc + signed({1'b0,mem_read_data}) * weight[addr_d1].
  - After the last address, next state DRAIN.
- DRAIN:
  - One cycle; accumulates the final pixel (address NUM_PIXELS-1).
  - Registers result_data = (RELU_EN && acc_final<0) ? 0 : acc_final.
  - Sets result_valid=1; next state DONE.
- DONE:
  - result_valid and result_data are held stable until result_ready=1.
  - On the handshake edge: result_valid<=0, next state IDLE.
  - start is ignored in DONE, including the handshake cycle.
- Latency:
  - Start accepted at edge E0; FETCH occupies cycles 1..16; DRAIN is cycle 17; result_valid=1 from cycle 18 (NUM_PIXELS+2).
  - Minimum start-to-start interval: NUM_PIXELS+3 cycles.
- Arithmetic:
  - Product width DATA_WIDTH+WEIGHT_WIDTH+1; sign-extended to ACC_WIDTH before the add.
  - No saturation; the parameter check guarantees no overflow.
- w_we while busy: dropped with no effect; weights are stable throughout a computation.
- Same-cycle start and w_we in IDLE: the weight write is performed and the computation starts. The written weight is used, because weight[0] is first read one cycle later.
- mem_read_addr holds its last value outside FETCH.

Decomposition:
- Package nn_pkg:
  - state enum (IDLE, FETCH, DRAIN, DONE).
  - Default width localparams.
  - ACC_WIDTH legality function.
- Sub-module mac_unit: signed multiply-accumulate with load (bias) and accumulate-enable inputs; instantiated once.
- The top level holds the FSM, address counter, latency pipeline and weight register file.

Test Plan:
1. Weights all 1, bias 0, BRAM pixels 0..15, pulse start -> result_valid rises exactly 18 cycles later; result_data=120; mem_read_addr sequence 0..15.
2. Weights all -1, pixels all 255, bias 0 -> RELU_EN=1 gives 0; RELU_EN=0 gives -4080.
3. Weights all -128, pixels all 255, bias 100, RELU_EN=0 -> -522140 with no wrap.
4. result_ready held low 5 cycles after valid -> valid and data stable; a start pulse in DONE is ignored; one cycle after the handshake, busy=0 and valid=0.
5. Start and w_we pulsed during FETCH -> no restart; weights unchanged; result identical to scenario 1.
6. rst asserted in FETCH cycle 7 -> next cycle IDLE, busy=0, valid=0, weights=0; a subsequent run yields bias only (e.g. bias=42 -> 42).
